// File: rtl/voice_scheduler.sv
// Per-sample voice scheduler: runs enabled voices in ascending order, muxes the
// shared multiplier/divider onto the running voice and produces a saturated mix.
module voice_scheduler #(
  parameter int NUM_VOICES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic [NUM_VOICES-1:0]       voice_en,
  output logic [NUM_VOICES-1:0]       voice_start,
  input  logic [NUM_VOICES-1:0]       voice_finish,
  input  logic [NUM_VOICES-1:0][23:0] voice_wave,
  input  logic [NUM_VOICES-1:0][31:0] voice_mult_a,
  input  logic [NUM_VOICES-1:0][31:0] voice_mult_b,
  input  logic [NUM_VOICES-1:0][47:0] voice_div_n,
  input  logic [NUM_VOICES-1:0][47:0] voice_div_d,
  output logic [31:0]                 mult_a,
  output logic [31:0]                 mult_b,
  output logic [47:0]                 div_n,
  output logic [47:0]                 div_d,
  output logic [23:0]                 mix_out,
  output logic                        mix_valid,
  output logic                        busy,
  output logic                        overrun
);
  // state | meaning
  // IDLE  | waiting for sample_tick (also the mix_valid cycle)
  // RUN   | voice cur is started and owns the multiplier/divider
  // SAT   | clamp accumulator into mix_out, pulse mix_valid

  localparam int CUR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = 24 + $clog2(NUM_VOICES) + 1;
  localparam logic signed [ACC_W-1:0] MIX_MAX = {{(ACC_W-24){1'b0}}, 24'h7FFFFF};
  localparam logic signed [ACC_W-1:0] MIX_MIN = {{(ACC_W-24){1'b1}}, 24'h800000};

  typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;

  state_t                  state;
  logic [NUM_VOICES-1:0]   pending;
  logic [CUR_W-1:0]        cur;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [NUM_VOICES-1:0]   cur_mask;
  logic [NUM_VOICES-1:0]   rest;
  logic [23:0]             clamped;

  function automatic logic [CUR_W-1:0] lowest(input logic [NUM_VOICES-1:0] m);
    lowest = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--)
      if (m[i]) lowest = CUR_W'(i);
  endfunction

  function automatic logic [NUM_VOICES-1:0] onehot(input logic [CUR_W-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (CUR_W'(i) == idx) onehot[i] = 1'b1;
  endfunction

  always_comb begin
    cur_mask = onehot(cur);
    rest     = pending & ~cur_mask;
    acc_next = acc + {{(ACC_W-24){voice_wave[cur][23]}}, voice_wave[cur]};
    if (acc > MIX_MAX)      clamped = 24'h7FFFFF;
    else if (acc < MIX_MIN) clamped = 24'h800000;
    else                    clamped = acc[23:0];
  end

  // Mux follows cur directly so a voice's pipelined result lines up with its own run.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    div_n  = '0;
    div_d  = '0;
    if (state == RUN) begin
      mult_a = voice_mult_a[cur];
      mult_b = voice_mult_b[cur];
      div_n  = voice_div_n[cur];
      div_d  = voice_div_d[cur];
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      cur         <= '0;
      acc         <= '0;
      voice_start <= '0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            pending <= voice_en;
            acc     <= '0;
            if (|voice_en) begin
              state       <= RUN;
              cur         <= lowest(voice_en);
              voice_start <= onehot(lowest(voice_en));
            end else begin
              state <= SAT;
            end
          end
        end
        RUN: begin
          if (sample_tick) overrun <= 1'b1;
          if (voice_finish[cur]) begin
            acc     <= acc_next;
            pending <= rest;
            // Handover in the same edge: the old start drops as the new one rises.
            if (|rest) begin
              cur         <= lowest(rest);
              voice_start <= onehot(lowest(rest));
            end else begin
              voice_start <= '0;
              state       <= SAT;
            end
          end
        end
        SAT: begin
          if (sample_tick) overrun <= 1'b1;
          mix_out   <= clamped;
          mix_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with four behavioural fixed-latency voices.
module tb_voice_scheduler;
  logic              clk;
  logic              rst;
  logic              sample_tick;
  logic [3:0]        voice_en;
  logic [3:0]        voice_start;
  logic [3:0]        voice_finish;
  logic [3:0][23:0]  voice_wave;
  logic [3:0][31:0]  voice_mult_a;
  logic [3:0][31:0]  voice_mult_b;
  logic [3:0][47:0]  voice_div_n;
  logic [3:0][47:0]  voice_div_d;
  logic [31:0]       mult_a;
  logic [31:0]       mult_b;
  logic [47:0]       div_n;
  logic [47:0]       div_d;
  logic [23:0]       mix_out;
  logic              mix_valid;
  logic              busy;
  logic              overrun;

  logic [3:0]        inj;
  int                run_cnt [4];
  int                lat_cfg [4] = '{5, 9, 3, 12};

  int                checks = 0;
  int                errors = 0;
  int                r_lat;
  int                r_starts;
  int                r_gaps;
  int                r_fin;
  logic [15:0]       r_order;
  logic [23:0]       r_mix;

  voice_scheduler #(.NUM_VOICES(4)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .voice_en(voice_en),
    .voice_start(voice_start), .voice_finish(voice_finish), .voice_wave(voice_wave),
    .voice_mult_a(voice_mult_a), .voice_mult_b(voice_mult_b),
    .voice_div_n(voice_div_n), .voice_div_d(voice_div_d),
    .mult_a(mult_a), .mult_b(mult_b), .div_n(div_n), .div_d(div_d),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Voice i raises finish in the lat_cfg[i]-th cycle of its start.
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (rst || !voice_start[i]) run_cnt[i] <= 0;
      else run_cnt[i] <= run_cnt[i] + 1;

  always_comb begin
    voice_finish = inj;
    for (int i = 0; i < 4; i++)
      if (voice_start[i] && run_cnt[i] == lat_cfg[i] - 1) voice_finish[i] = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic int idx_of(input logic [3:0] m);
    idx_of = 0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) idx_of = i;
  endfunction

  task automatic chk_mux_zero(input string tag);
    chk({tag, "_mult_a"}, 64'(mult_a), 64'h0);
    chk({tag, "_mult_b"}, 64'(mult_b), 64'h0);
    chk({tag, "_div_n"}, 64'(div_n), 64'h0);
    chk({tag, "_div_d"}, 64'(div_d), 64'h0);
  endtask

  // Ticks once, then follows the run until mix_valid; tick_at re-ticks mid-run.
  task automatic run_sample(input logic [3:0] en, input int tick_at);
    int cnt;
    int k;
    logic [3:0] prev;
    r_order = '0; r_starts = 0; r_gaps = 0; r_fin = 0;
    voice_en = en;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    prev = '0;
    cnt = 1;
    while (!mix_valid && cnt < 300) begin
      chk("start_onehot", 64'($onehot0(voice_start)), 64'h1);
      if (voice_start != 4'b0) begin
        k = idx_of(voice_start);
        if (voice_start != prev) begin
          r_order = {r_order[11:0], 4'(k)};
          r_starts++;
        end
        chk("mux_mult_a", 64'(mult_a), 64'(32'hA000_0000 | 32'(k)));
        chk("mux_mult_b", 64'(mult_b), 64'(32'hB000_0000 | 32'(k)));
        chk("mux_div_n", 64'(div_n), 64'(48'hC000_0000_0000 | 48'(k)));
        chk("mux_div_d", 64'(div_d), 64'(48'hD000_0000_0000 | 48'(k)));
        if (voice_finish[k]) r_fin = cnt;
      end else begin
        if (busy) r_gaps++;
        chk_mux_zero("mux_idle");
      end
      prev = voice_start;
      sample_tick = (cnt == tick_at);
      step();
      sample_tick = 1'b0;
      cnt++;
    end
    r_lat = cnt;
    r_mix = mix_out;
    chk("mix_valid_seen", 64'(mix_valid), 64'h1);
    chk_mux_zero("mux_valid_cycle");
  endtask

  initial begin
    int mv;
    clk = 1'b0; rst = 1'b1; sample_tick = 1'b0; voice_en = '0; inj = '0;
    for (int i = 0; i < 4; i++) begin
      voice_wave[i]   = '0;
      voice_mult_a[i] = 32'hA000_0000 | 32'(i);
      voice_mult_b[i] = 32'hB000_0000 | 32'(i);
      voice_div_n[i]  = 48'hC000_0000_0000 | 48'(i);
      voice_div_d[i]  = 48'hD000_0000_0000 | 48'(i);
    end
    do_reset();
    chk("rst_start", 64'(voice_start), 64'h0);
    chk("rst_mix_out", 64'(mix_out), 64'h0);
    chk("rst_mix_valid", 64'(mix_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
    chk_mux_zero("rst_mux");

    // Basic run: 100 + 200 - 50 + 7 = 257, latency 2+5+9+3+12 = 31.
    voice_wave = {24'h000007, 24'hFFFFCE, 24'h0000C8, 24'h000064};
    run_sample(4'hF, -1);
    chk("basic_order", 64'(r_order), 64'h0123);
    chk("basic_starts", 64'(r_starts), 64'd4);
    chk("basic_gaps", 64'(r_gaps), 64'd1);
    chk("basic_latency", 64'(r_lat), 64'd31);
    chk("basic_fin_to_valid", 64'(r_lat - r_fin), 64'd2);
    chk("basic_mix", 64'(r_mix), 64'h000101);
    step();
    chk("basic_valid_one_cycle", 64'(mix_valid), 64'h0);
    chk("basic_busy_after", 64'(busy), 64'h0);

    voice_wave = {4{24'h7FFFFF}};
    run_sample(4'hF, -1);
    chk("sat_pos", 64'(r_mix), 64'h7FFFFF);
    voice_wave = {4{24'h800000}};
    run_sample(4'hF, -1);
    chk("sat_neg", 64'(r_mix), 64'h800000);
    // 8388607*2 - 8388608 + 1 = 8388607: only correct if the sum never wraps.
    voice_wave = {24'h000001, 24'h800000, 24'h7FFFFF, 24'h7FFFFF};
    run_sample(4'hF, -1);
    chk("sat_mixed", 64'(r_mix), 64'h7FFFFF);
    voice_wave = {24'h000000, 24'h000001, 24'h800000, 24'h7FFFFF};
    run_sample(4'hF, -1);
    chk("sum_zero", 64'(r_mix), 64'h000000);

    // Voices 0 and 2 only, voice 1 finish held high throughout: 1000 - 3000 = -2000.
    voice_wave = {24'h000009, 24'hFFF448, 24'h123456, 24'h0003E8};
    inj = 4'b0010;
    run_sample(4'b0101, -1);
    inj = 4'b0000;
    chk("en0101_order", 64'(r_order), 64'h0002);
    chk("en0101_starts", 64'(r_starts), 64'd2);
    chk("en0101_latency", 64'(r_lat), 64'd10);
    chk("en0101_mix", 64'(r_mix), 64'hFFF830);

    run_sample(4'b0000, -1);
    chk("en0000_latency", 64'(r_lat), 64'd2);
    chk("en0000_mix", 64'(r_mix), 64'h0);
    chk("en0000_starts", 64'(r_starts), 64'd0);
    chk("no_overrun_yet", 64'(overrun), 64'h0);

    // Extra tick mid-run is dropped and flagged.
    voice_wave = {24'h000007, 24'hFFFFCE, 24'h0000C8, 24'h000064};
    run_sample(4'hF, 10);
    chk("ovr_flag", 64'(overrun), 64'h1);
    chk("ovr_latency", 64'(r_lat), 64'd31);
    chk("ovr_mix", 64'(r_mix), 64'h000101);
    run_sample(4'h0, -1);
    chk("ovr_sticky", 64'(overrun), 64'h1);
    chk("ovr_next_mix", 64'(r_mix), 64'h0);

    // Tick coincident with mix_valid is accepted.
    do_reset();
    chk("rst_clears_overrun", 64'(overrun), 64'h0);
    run_sample(4'hF, -1);
    run_sample(4'hF, -1);
    chk("b2b_overrun", 64'(overrun), 64'h0);
    chk("b2b_latency", 64'(r_lat), 64'd31);
    chk("b2b_order", 64'(r_order), 64'h0123);
    chk("b2b_mix", 64'(r_mix), 64'h000101);

    // Reset in the middle of voice 2.
    voice_en = 4'hF;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    mv = 0;
    while (voice_start != 4'b0100 && mv < 100) begin
      step();
      mv++;
    end
    chk("reach_voice2", 64'(voice_start), 64'h4);
    step();
    rst = 1'b1;
    step();
    chk("midrst_start", 64'(voice_start), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_mix_out", 64'(mix_out), 64'h0);
    chk("midrst_mix_valid", 64'(mix_valid), 64'h0);
    chk("midrst_overrun", 64'(overrun), 64'h0);
    chk_mux_zero("midrst_mux");
    rst = 1'b0;
    mv = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mix_valid || voice_start != 4'b0) mv++;
    end
    chk("midrst_quiet", 64'(mv), 64'd0);
    run_sample(4'hF, -1);
    chk("post_rst_order", 64'(r_order), 64'h0123);
    chk("post_rst_latency", 64'(r_lat), 64'd31);
    chk("post_rst_mix", 64'(r_mix), 64'h000101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
